// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor: d = a - b over WIDTH bits, LSB first.
//   Each RUN cycle performs one full-subtract step built from two cascaded
//   half-subtractor cells plus a borrow flip-flop. Valid/ready handshakes on
//   both the operand and the result side.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair a/b is valid
//   in_ready   block can accept operands (state IDLE)
//   a, b       minuend / subtrahend, unsigned, WIDTH bits
//   out_valid  d/bout valid (state DONE)
//   out_ready  consumer accepts the result
//   d          (a - b) mod 2^WIDTH
//   bout       final borrow, 1 iff a < b
//   busy       high while bits are being processed (state RUN)
// -----------------------------------------------------------------------------

// Half-subtractor cell: diff = x - y, borrow when y > x.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic borrow
);
  assign diff   = x ^ y;
  assign borrow = ~x & y;
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value on the edge that processes the most significant bit.
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // One full-subtract step on the current LSBs and the stored borrow.
  logic h, b1, di, b2, borrow_next;

  half_subtractor u_hs_operands (
    .x      (a_sr_q[0]),
    .y      (b_sr_q[0]),
    .diff   (h),
    .borrow (b1)
  );

  half_subtractor u_hs_borrow (
    .x      (h),
    .y      (br_q),
    .diff   (di),
    .borrow (b2)
  );

  assign borrow_next = b1 | b2;

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    d_d     = d_q;
    bout_d  = bout_q;
    br_d    = br_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        // Result bits enter at the MSB; after WIDTH shifts the first
        // computed bit has arrived at bit 0.
        d_d    = {di, d_q[WIDTH-1:1]};
        br_d   = borrow_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          bout_d  = borrow_next;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign bout      = bout_q;

endmodule
